// File: rtl/vector_operand_pack_if.sv
// Operand/result bundle for vector_operand_pack: two operand streams in,
// one packed pair stream out, plus FIFO occupancy status.
interface vector_operand_pack_if #(
  parameter int C_OP_WIDTH     = 16,
  parameter int C_NUM_OPERANDS = 1,
  parameter int C_FIFO_DEPTH   = 4
);
  localparam int W  = C_OP_WIDTH * C_NUM_OPERANDS;
  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;

  logic [W-1:0]   op0_datain;
  logic           op0_datain_valid;
  logic           op0_datain_ready;
  logic [W-1:0]   op1_datain;
  logic           op1_datain_valid;
  logic           op1_datain_ready;
  logic [2*W-1:0] dout;
  logic           dout_valid;
  logic           dout_ready;
  logic [CW-1:0]  op0_count;
  logic [CW-1:0]  op1_count;

  modport master (
    output op0_datain, op0_datain_valid, op1_datain, op1_datain_valid, dout_ready,
    input  op0_datain_ready, op1_datain_ready, dout, dout_valid, op0_count, op1_count
  );

  modport slave (
    input  op0_datain, op0_datain_valid, op1_datain, op1_datain_valid, dout_ready,
    output op0_datain_ready, op1_datain_ready, dout, dout_valid, op0_count, op1_count
  );
endinterface

// File: rtl/vector_operand_pack.sv
// Buffers two operand-vector streams in small FIFOs and joins their heads in
// arrival order into one registered {op1, op0} word for the multiplier.
module vector_operand_pack #(
  parameter int C_OP_WIDTH     = 16,
  parameter int C_NUM_OPERANDS = 1,
  parameter int C_FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  vector_operand_pack_if.slave  bus
);
  localparam int W  = C_OP_WIDTH * C_NUM_OPERANDS;
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(C_FIFO_DEPTH);

  logic [W-1:0]   mem0 [C_FIFO_DEPTH];
  logic [W-1:0]   mem1 [C_FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
  logic [CW-1:0]  count0, count1;
  logic [2*W-1:0] dout_q;
  logic           dout_valid_q;
  logic           wr0, wr1, free, pop;

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // never lets a full FIFO take a new word.
  assign bus.op0_datain_ready = !rst && (count0 < DEPTH);
  assign bus.op1_datain_ready = !rst && (count1 < DEPTH);

  assign wr0  = bus.op0_datain_valid && bus.op0_datain_ready;
  assign wr1  = bus.op1_datain_valid && bus.op1_datain_ready;
  assign free = !dout_valid_q || bus.dout_ready;
  assign pop  = (count0 != '0) && (count1 != '0) && free;

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.op0_count  = count0;
  assign bus.op1_count  = count1;

  always_ff @(posedge clk) begin
    if (wr0) mem0[wr_ptr0] <= bus.op0_datain;
    if (wr1) mem1[wr_ptr1] <= bus.op1_datain;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr0      <= '0;
      rd_ptr0      <= '0;
      wr_ptr1      <= '0;
      rd_ptr1      <= '0;
      count0       <= '0;
      count1       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (wr0) wr_ptr0 <= wr_ptr0 + 1'b1;
      if (wr1) wr_ptr1 <= wr_ptr1 + 1'b1;

      if (pop) begin
        rd_ptr0      <= rd_ptr0 + 1'b1;
        rd_ptr1      <= rd_ptr1 + 1'b1;
        dout_q       <= {mem1[rd_ptr1], mem0[rd_ptr0]};
        dout_valid_q <= 1'b1;
      end else if (bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end

      case ({wr0, pop})
        2'b10:   count0 <= count0 + 1'b1;
        2'b01:   count0 <= count0 - 1'b1;
        default: count0 <= count0;
      endcase

      case ({wr1, pop})
        2'b10:   count1 <= count1 + 1'b1;
        2'b01:   count1 <= count1 - 1'b1;
        default: count1 <= count1;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_operand_pack.sv
// Bench for vector_operand_pack: directed scenarios on a 16x1/depth-4 instance
// against a queue model, and a random 16x4/depth-8 instance against a scoreboard.
module tb_vector_operand_pack;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vector_operand_pack_if #(.C_OP_WIDTH(16), .C_NUM_OPERANDS(1), .C_FIFO_DEPTH(4)) bus_a ();
  vector_operand_pack_if #(.C_OP_WIDTH(16), .C_NUM_OPERANDS(4), .C_FIFO_DEPTH(8)) bus_b ();

  vector_operand_pack #(.C_OP_WIDTH(16), .C_NUM_OPERANDS(1), .C_FIFO_DEPTH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  vector_operand_pack #(.C_OP_WIDTH(16), .C_NUM_OPERANDS(4), .C_FIFO_DEPTH(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive instance A for the next edge, then return just after that edge.
  task automatic applyStimulus(input logic r, input logic v0, input logic [15:0] d0,
                               input logic v1, input logic [15:0] d1, input logic dr);
    rst                    = r;
    bus_a.op0_datain_valid = v0;
    bus_a.op0_datain       = d0;
    bus_a.op1_datain_valid = v1;
    bus_a.op1_datain       = d1;
    bus_a.dout_ready       = dr;
    @(posedge clk);
    #1;
  endtask

  // Instance A model: operand queues plus the output register, stepped per edge.
  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  logic        mvalid;
  logic [31:0] mdout;
  bit          model_live = 1'b0;

  always @(posedge clk) begin : model_a
    bit r0, r1, fr, pp;
    logic [15:0] h0, h1;
    if (rst) begin
      mq0.delete();
      mq1.delete();
      mvalid     = 1'b0;
      mdout      = '0;
      model_live = 1'b1;
    end else begin
      r0 = mq0.size() < 4;
      r1 = mq1.size() < 4;
      fr = !mvalid || bus_a.dout_ready;
      pp = (mq0.size() > 0) && (mq1.size() > 0) && fr;
      if (pp) begin
        h0     = mq0.pop_front();
        h1     = mq1.pop_front();
        mdout  = {h1, h0};
        mvalid = 1'b1;
      end else if (bus_a.dout_ready) begin
        mvalid = 1'b0;
      end
      if (bus_a.op0_datain_valid && r0) mq0.push_back(bus_a.op0_datain);
      if (bus_a.op1_datain_valid && r1) mq1.push_back(bus_a.op1_datain);
    end
  end

  // Instance B scoreboard: everything accepted but not yet handed downstream.
  logic [63:0]  sb0[$];
  logic [63:0]  sb1[$];
  int           pairs_b = 0;
  bit           prev_hold = 1'b0;
  logic [127:0] prev_dout_b;

  always @(negedge clk) begin : compare
    int           exp_c0, exp_c1;
    logic [63:0]  h0, h1;
    if (model_live) begin
      checkOutput("a_dout_valid", 128'(bus_a.dout_valid), 128'(mvalid));
      checkOutput("a_dout", 128'(bus_a.dout), 128'(mdout));
      checkOutput("a_op0_count", 128'(bus_a.op0_count), 128'(mq0.size()));
      checkOutput("a_op1_count", 128'(bus_a.op1_count), 128'(mq1.size()));
      checkOutput("a_op0_ready", 128'(bus_a.op0_datain_ready), 128'(!rst && mq0.size() < 4));
      checkOutput("a_op1_ready", 128'(bus_a.op1_datain_ready), 128'(!rst && mq1.size() < 4));

      if (rst) begin
        sb0.delete();
        sb1.delete();
        prev_hold = 1'b0;
      end else begin
        exp_c0 = sb0.size() - (bus_b.dout_valid ? 1 : 0);
        exp_c1 = sb1.size() - (bus_b.dout_valid ? 1 : 0);
        checkOutput("b_op0_count", 128'(bus_b.op0_count), 128'(exp_c0));
        checkOutput("b_op1_count", 128'(bus_b.op1_count), 128'(exp_c1));
        checkOutput("b_op0_ready", 128'(bus_b.op0_datain_ready), 128'(exp_c0 < 8));
        checkOutput("b_op1_ready", 128'(bus_b.op1_datain_ready), 128'(exp_c1 < 8));
        if (prev_hold) begin
          checkOutput("b_hold_valid", 128'(bus_b.dout_valid), 128'(1));
          checkOutput("b_hold_dout", bus_b.dout, prev_dout_b);
        end
        if (bus_b.dout_valid && bus_b.dout_ready) begin
          checkOutput("b_pair_available", 128'((sb0.size() > 0) && (sb1.size() > 0)), 128'(1));
          if ((sb0.size() > 0) && (sb1.size() > 0)) begin
            h0 = sb0.pop_front();
            h1 = sb1.pop_front();
            checkOutput("b_pair", bus_b.dout, {h1, h0});
          end
          pairs_b++;
        end
        if (bus_b.op0_datain_valid && bus_b.op0_datain_ready) sb0.push_back(bus_b.op0_datain);
        if (bus_b.op1_datain_valid && bus_b.op1_datain_ready) sb1.push_back(bus_b.op1_datain);
        prev_hold   = bus_b.dout_valid && !bus_b.dout_ready;
        prev_dout_b = bus_b.dout;
      end
    end
  end

  initial begin
    bus_b.op0_datain_valid = 1'b0;
    bus_b.op0_datain       = '0;
    bus_b.op1_datain_valid = 1'b0;
    bus_b.op1_datain       = '0;
    bus_b.dout_ready       = 1'b0;

    // Reset held with both valids high: nothing may be accepted.
    repeat (3) applyStimulus(1, 1, 16'hDEAD, 1, 16'hBEEF, 0);
    checkOutput("rst_ready0", 128'(bus_a.op0_datain_ready), 128'(0));
    checkOutput("rst_ready1", 128'(bus_a.op1_datain_ready), 128'(0));
    checkOutput("rst_valid", 128'(bus_a.dout_valid), 128'(0));
    checkOutput("rst_dout", 128'(bus_a.dout), 128'(0));
    checkOutput("rst_count0", 128'(bus_a.op0_count), 128'(0));
    checkOutput("rst_count1", 128'(bus_a.op1_count), 128'(0));
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("post_rst_ready0", 128'(bus_a.op0_datain_ready), 128'(1));
    checkOutput("post_rst_count0", 128'(bus_a.op0_count), 128'(0));

    // Basic pair: two-cycle latency, drops when consumed.
    applyStimulus(0, 1, 16'h0003, 1, 16'h0005, 1);
    checkOutput("t2_valid_e0", 128'(bus_a.dout_valid), 128'(0));
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t2_valid_e1", 128'(bus_a.dout_valid), 128'(1));
    checkOutput("t2_dout", 128'(bus_a.dout), 128'(32'h0005_0003));
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t2_valid_e2", 128'(bus_a.dout_valid), 128'(0));

    // Skew to full, then a pop edge must still refuse the op0 write.
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 16'(i), 0, 0, 1);
    checkOutput("t3_count0_full", 128'(bus_a.op0_count), 128'(4));
    checkOutput("t3_ready0_full", 128'(bus_a.op0_datain_ready), 128'(0));
    checkOutput("t3_valid_idle", 128'(bus_a.dout_valid), 128'(0));
    applyStimulus(0, 1, 16'd99, 1, 16'd10, 1);
    applyStimulus(0, 1, 16'd99, 1, 16'd20, 1);
    checkOutput("t3_pair1", 128'(bus_a.dout), 128'(32'h000A_0001));
    checkOutput("t3_no_write_on_pop", 128'(bus_a.op0_count), 128'(3));
    applyStimulus(0, 0, 0, 1, 16'd30, 1);
    checkOutput("t3_pair2", 128'(bus_a.dout), 128'(32'h0014_0002));
    applyStimulus(0, 0, 0, 1, 16'd40, 1);
    checkOutput("t3_pair3", 128'(bus_a.dout), 128'(32'h001E_0003));
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t3_pair4", 128'(bus_a.dout), 128'(32'h0028_0004));
    checkOutput("t3_count0_end", 128'(bus_a.op0_count), 128'(0));
    checkOutput("t3_count1_end", 128'(bus_a.op1_count), 128'(0));
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Backpressure: first pair held while two more wait in the FIFOs.
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 16'(8'h10 + i), 1, 16'(8'h20 + i), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t4_hold_dout", 128'(bus_a.dout), 128'(32'h0021_0011));
      checkOutput("t4_hold_valid", 128'(bus_a.dout_valid), 128'(1));
      checkOutput("t4_hold_count", 128'(bus_a.op0_count), 128'(2));
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_pair2", 128'(bus_a.dout), 128'(32'h0022_0012));
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_pair3", 128'(bus_a.dout), 128'(32'h0023_0013));
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_drained", 128'(bus_a.dout_valid), 128'(0));

    // Mid-operation reset discards buffered and output data.
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 16'(8'h30 + i), 1, 16'(8'h40 + i), 0);
    checkOutput("t5_pre_valid", 128'(bus_a.dout_valid), 128'(1));
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t5_count0", 128'(bus_a.op0_count), 128'(0));
    checkOutput("t5_count1", 128'(bus_a.op1_count), 128'(0));
    checkOutput("t5_valid", 128'(bus_a.dout_valid), 128'(0));
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 16'h0007, 1, 16'h0009, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t5_new_valid", 128'(bus_a.dout_valid), 128'(1));
    checkOutput("t5_new_dout", 128'(bus_a.dout), 128'(32'h0009_0007));
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Random traffic on instance B, alternating easy and heavy backpressure.
    for (int c = 0; c < 40000 && pairs_b < 1000; c++) begin
      bus_b.op0_datain_valid = ($urandom_range(0, 3) != 0);
      bus_b.op0_datain       = {$urandom(), $urandom()};
      bus_b.op1_datain_valid = ($urandom_range(0, 3) != 0);
      bus_b.op1_datain       = {$urandom(), $urandom()};
      if (((c / 200) % 2) == 0) bus_b.dout_ready = ($urandom_range(0, 3) != 0);
      else                      bus_b.dout_ready = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    checkOutput("b_pairs_done", 128'(pairs_b >= 1000), 128'(1));
    bus_b.op0_datain_valid = 1'b0;
    bus_b.op1_datain_valid = 1'b0;
    bus_b.dout_ready       = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vector_operand_pack.md
Name: vector_operand_pack

Overview:
Transmit-side feeder for the vector multiply stage. It accepts two independent operand-vector streams (op0 and op1), each with its own valid/ready handshake, and buffers each stream in a small FIFO. It pairs the heads of the two FIFOs in arrival order. Each pair is presented as one packed datain word on a registered valid/ready output, in exactly the lane layout the multiplier consumes.

Parameters:
C_OP_WIDTH, 16, width of one operand lane in bits
C_NUM_OPERANDS, 1, lanes per operand vector
C_FIFO_DEPTH, 4, entries per operand FIFO; power of 2, >= 2
(derived) W = C_OP_WIDTH*C_NUM_OPERANDS; CW = clog2(C_FIFO_DEPTH)+1

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
op0_datain  input  W  operand-0 vector
op0_datain_valid  input  1  op0 word valid
op0_datain_ready  output  1  op0 FIFO can accept
op1_datain  input  W  operand-1 vector
op1_datain_valid  input  1  op1 word valid
op1_datain_ready  output  1  op1 FIFO can accept
dout  output  2*W  packed pair to multiplier
dout_valid  output  1  dout holds a pair
dout_ready  input  1  downstream accepts dout
op0_count  output  CW  op0 FIFO occupancy
op1_count  output  CW  op1 FIFO occupancy

Behaviour:
- Reset (sync, active-high): at the first clk edge with rst=1, clear both FIFO read/write pointers and both counts to 0, set dout_valid=0 and dout=0. Reset asserted mid-operation discards all buffered and output data; none of it ever appears on dout.
- opX_datain_ready = !rst && (opX_count < C_FIFO_DEPTH). This is combinational from registered count; no pass-through.
- FIFO write: on a clk edge with opX_datain_valid && opX_datain_ready. The data is stored at the write pointer, and the pointer wraps modulo C_FIFO_DEPTH.
- A full FIFO does not accept a write even if it pops in the same cycle. Ready stays low for that cycle.
- Output slot free: free = !dout_valid || dout_ready.
- Join/pop: pop = (op0_count>0) && (op1_count>0) && free.
  - On pop, both FIFOs advance their read pointers in the same edge.
  - dout <= {op1_head, op0_head}, and dout_valid <= 1.
- If free is true but no pop occurs and dout_ready=1, then dout_valid <= 0. dout keeps its last value and is don't-care to consumers.
- Counts: opX_count increments on write only, decrements on pop only, and is unchanged on simultaneous write+pop.
- Packing:
  - dout[W-1:0] = op0 vector; dout[2W-1:W] = op1 vector.
  - Lane i of each half sits at [i*C_OP_WIDTH +: C_OP_WIDTH], unmodified (no sign handling, no arithmetic).
- Hold rule: while dout_valid=1 && dout_ready=0, dout and dout_valid are stable.
- Latency: a word accepted at edge E is readable from the FIFO after E, can pop at E+1, and so dout_valid is high after E+1. Minimum latency is 2 cycles.
- Throughput: 1 pair per cycle sustained when both inputs stream and dout_ready=1.
- Ordering: pairs are formed strictly as the k-th op0 with the k-th op1. One stream may run up to C_FIFO_DEPTH words ahead. Beyond that, its ready drops.
- Unequal totals: an unmatched remainder stays buffered indefinitely until a partner arrives or reset.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with both valids high -> both readies=0, dout_valid=0, dout=0, counts=0. After release, readies=1 and no stale writes occurred.
2. Basic pair (W=16, N=1): op0=0x0003 and op1=0x0005 accepted at edge 0 -> dout_valid=1 after edge 1, dout=0x00050003. With dout_ready=1 it drops after edge 2.
3. Skew/full: push op0 = 1,2,3,4 back-to-back with no op1 -> op0_count=4, op0_datain_ready=0, dout_valid=0. Then stream op1 = 10,20,30,40 with dout_ready=1 -> dout = {10,1},{20,2},{30,3},{40,4} on consecutive cycles; counts end at 0.
4. Backpressure: 3 pairs buffered, dout_ready=0 for 5 cycles -> dout={first pair} stable, dout_valid=1, counts=2. Release -> remaining pairs follow in order, no loss or duplication.
5. Mid-operation reset: 2 words in each FIFO and dout_valid=1, pulse rst 1 cycle -> next cycle counts=0 and dout_valid=0. Old data is never output; new pairs behave as in scenario 2.
6. Random (N=4, C_FIFO_DEPTH=8): random valid on both inputs and random dout_ready, 1000 pairs -> scoreboard matches k-th op0 with k-th op1 in order. No handshake violations occur, and counts never exceed 8.
